// File: rtl/seg6_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg6_scan_driver_if
// Bundles the load/data side and the display side of the six-digit
// seven-segment scan driver.
//   load          1-cycle strobe capturing the digit inputs and len
//   out100000..1  BCD digits, 100000s down to ones
//   len           number of significant digits (1..6, clamped)
//   an            active-low digit enables, an[0] = ones
//   seg           active-low segments {g,f,e,d,c,b,a}
//   pending       a captured value is waiting for the frame boundary
//   frame_done    one-cycle pulse on the frame-wrap tick
// master = the side feeding digits, slave = the driver itself.
// ---------------------------------------------------------------------------
interface seg6_scan_driver_if;
    logic       load;
    logic [3:0] out100000;
    logic [3:0] out10000;
    logic [3:0] out1000;
    logic [3:0] out100;
    logic [3:0] out10;
    logic [3:0] out1;
    logic [2:0] len;
    logic [5:0] an;
    logic [6:0] seg;
    logic       pending;
    logic       frame_done;

    modport master (
        output load, out100000, out10000, out1000, out100, out10, out1, len,
        input  an, seg, pending, frame_done
    );

    modport slave (
        input  load, out100000, out10000, out1000, out100, out10, out1, len,
        output an, seg, pending, frame_done
    );
endinterface

// File: rtl/seg6_scan_driver.sv
// ---------------------------------------------------------------------------
// seg6_scan_driver
// Multiplexed driver for a six-digit common-anode seven-segment display.
// A prescaler divides clk by DIV to form the per-digit slot; the scan index
// walks positions 0..5 (ones first). New values are double-buffered: a load
// lands in a pending register and is promoted to the displayed (active)
// register only on the frame boundary, so a frame is never torn.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    seg6_scan_driver_if.slave (load/digits/len in, an/seg/status out)
// ---------------------------------------------------------------------------
module seg6_scan_driver #(
    parameter int DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    seg6_scan_driver_if.slave   bus
);

    localparam logic [15:0] PRESC_MAX = 16'(DIV - 1);

    // Active-high segment code {g,f,e,d,c,b,a}; 10..15 show a minus sign.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'h3F;
            4'd1:    seg_code = 7'h06;
            4'd2:    seg_code = 7'h5B;
            4'd3:    seg_code = 7'h4F;
            4'd4:    seg_code = 7'h66;
            4'd5:    seg_code = 7'h6D;
            4'd6:    seg_code = 7'h7D;
            4'd7:    seg_code = 7'h07;
            4'd8:    seg_code = 7'h7F;
            4'd9:    seg_code = 7'h6F;
            default: seg_code = 7'h40;
        endcase
    endfunction

    // Length 0 still shows the ones digit; 7 is treated as all six.
    function automatic logic [2:0] clamp_len(input logic [2:0] l);
        if (l == 3'd0)      clamp_len = 3'd1;
        else if (l == 3'd7) clamp_len = 3'd6;
        else                clamp_len = l;
    endfunction

    logic [15:0] presc_q, presc_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] act_dig_q, act_dig_d;
    logic [2:0]  act_len_q, act_len_d;
    logic [23:0] pend_dig_q, pend_dig_d;
    logic [2:0]  pend_len_q, pend_len_d;
    logic        pending_q, pending_d;
    logic [5:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    logic        tick;
    logic        boundary;
    logic [23:0] load_dig;
    logic [2:0]  eff_len;
    logic [3:0]  cur_dig;

    assign tick     = (presc_q == PRESC_MAX);
    assign boundary = tick && (idx_q == 3'd5);
    assign load_dig = {bus.out100000, bus.out10000, bus.out1000,
                       bus.out100, bus.out10, bus.out1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            act_dig_q  <= '0;
            act_len_q  <= 3'd1;
            pend_dig_q <= '0;
            pend_len_q <= '0;
            pending_q  <= 1'b0;
            an_q       <= '1;
            seg_q      <= '1;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            act_dig_q  <= act_dig_d;
            act_len_q  <= act_len_d;
            pend_dig_q <= pend_dig_d;
            pend_len_q <= pend_len_d;
            pending_q  <= pending_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    // Timing chain and double-buffered value registers.
    always_comb begin
        presc_d    = tick ? '0 : presc_q + 16'd1;
        idx_d      = idx_q;
        act_dig_d  = act_dig_q;
        act_len_d  = act_len_q;
        pend_dig_d = pend_dig_q;
        pend_len_d = pend_len_q;
        pending_d  = pending_q;

        if (tick) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        if (boundary) begin
            // A load on the boundary itself bypasses the pending stage.
            pending_d = 1'b0;
            if (bus.load) begin
                act_dig_d = load_dig;
                act_len_d = bus.len;
            end else if (pending_q) begin
                act_dig_d = pend_dig_q;
                act_len_d = pend_len_q;
            end
        end else if (bus.load) begin
            pend_dig_d = load_dig;
            pend_len_d = bus.len;
            pending_d  = 1'b1;
        end
    end

    // Registered display outputs for the current scan position.
    always_comb begin
        eff_len = clamp_len(act_len_q);
        cur_dig = '0;
        for (int i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) cur_dig = act_dig_q[4*i +: 4];
        end
        if (idx_q >= eff_len) begin
            an_d  = '1;
            seg_d = '1;
        end else begin
            an_d  = ~(6'b000001 << idx_q);
            seg_d = ~seg_code(cur_dig);
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.pending    = pending_q;
    assign bus.frame_done = boundary;

endmodule

// File: tb/tb_seg6_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg6_scan_driver
// Directed bench for seg6_scan_driver with DIV=4 (24-cycle frame).
// ---------------------------------------------------------------------------
module tb_seg6_scan_driver;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    seg6_scan_driver_if bus ();

    seg6_scan_driver #(.DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_val(input logic [23:0] digs, input logic [2:0] l);
        bus.out100000 = digs[23:20];
        bus.out10000  = digs[19:16];
        bus.out1000   = digs[15:12];
        bus.out100    = digs[11:8];
        bus.out10     = digs[7:4];
        bus.out1      = digs[3:0];
        bus.len       = l;
        bus.load      = 1'b1;
    endtask

    // Entered on the first cycle position 0 is displayed; checks one whole
    // frame and returns on the first position-0 cycle of the next frame.
    // Any load strobe raised by the caller is dropped after the first edge.
    task automatic check_frame(input string tag, input logic [41:0] codes,
                               input logic [5:0] mask, input logic exp_pend);
        logic [5:0] exp_an;
        logic [6:0] exp_seg;
        int p;
        for (int i = 0; i < 24; i++) begin
            p = i / 4;
            if (mask[p]) begin
                exp_an  = ~(6'b000001 << p);
                exp_seg = codes[7*p +: 7];
            end else begin
                exp_an  = 6'b111111;
                exp_seg = 7'b1111111;
            end
            check_eq({tag, "_an"}, 64'(bus.an), 64'(exp_an));
            check_eq({tag, "_seg"}, 64'(bus.seg), 64'(exp_seg));
            check_eq({tag, "_fd"}, 64'(bus.frame_done), 64'(i == 22));
            if (i == 10) check_eq({tag, "_pend"}, 64'(bus.pending), 64'(exp_pend));
            step();
            bus.load = 1'b0;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.load = 1'b0;
        bus.out100000 = '0; bus.out10000 = '0; bus.out1000 = '0;
        bus.out100 = '0; bus.out10 = '0; bus.out1 = '0;
        bus.len = 3'd1;

        // Reset state
        repeat (3) step();
        check_eq("rst_an", 64'(bus.an), 64'h3F);
        check_eq("rst_seg", 64'(bus.seg), 64'h7F);
        check_eq("rst_pend", 64'(bus.pending), 64'h0);
        check_eq("rst_fd", 64'(bus.frame_done), 64'h0);
        rst_n = 1'b1;
        step();

        // Idle frame after reset: "0" on the ones digit only
        check_frame("idle", {6{7'h40}}, 6'b000001, 1'b0);

        // 1,2,3,4,5,6 loaded mid-frame: held until the boundary
        load_val(24'h123456, 3'd6);
        check_frame("hold1", {6{7'h40}}, 6'b000001, 1'b1);
        check_eq("pend_clr1", 64'(bus.pending), 64'h0);
        check_frame("d123456", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02},
                    6'b111111, 1'b0);

        // 0,0,0,0,4,2 with len=2
        load_val(24'h000042, 3'd2);
        check_frame("hold2", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02},
                    6'b111111, 1'b1);
        check_frame("len2", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24},
                    6'b000011, 1'b0);

        // Two loads in one frame: 7 then 9, last wins
        load_val(24'h000007, 3'd1);
        step();
        bus.load = 1'b0;
        repeat (9) step();
        check_eq("pend_two", 64'(bus.pending), 64'h1);
        load_val(24'h000009, 3'd1);
        step();
        bus.load = 1'b0;
        repeat (13) step();
        check_frame("last9", {6{7'h10}}, 6'b000001, 1'b0);

        // Load on the boundary tick goes straight to the active register
        repeat (22) step();
        check_eq("bnd_fd", 64'(bus.frame_done), 64'h1);
        load_val(24'h000008, 3'd1);
        step();
        bus.load = 1'b0;
        check_eq("bnd_pend", 64'(bus.pending), 64'h0);
        step();
        check_frame("bnd8", {6{7'h00}}, 6'b000001, 1'b0);

        // Non-BCD ones digit with len=0: minus on position 0
        load_val(24'h00000C, 3'd0);
        check_frame("hold3", {6{7'h00}}, 6'b000001, 1'b1);
        check_frame("minus", {6{7'h3F}}, 6'b000001, 1'b0);

        // Reset mid-frame with pending data discards it
        load_val(24'h555555, 3'd6);
        step();
        bus.load = 1'b0;
        repeat (3) step();
        check_eq("mid_pend", 64'(bus.pending), 64'h1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_an", 64'(bus.an), 64'h3F);
        check_eq("arst_seg", 64'(bus.seg), 64'h7F);
        check_eq("arst_pend", 64'(bus.pending), 64'h0);
        check_eq("arst_fd", 64'(bus.frame_done), 64'h0);
        step();
        rst_n = 1'b1;
        step();
        check_frame("post1", {6{7'h40}}, 6'b000001, 1'b0);
        check_frame("post2", {6{7'h40}}, 6'b000001, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
